// File: rtl/usr_pkg.sv
// Shared definitions for universal_shift_reg: mode encodings and per-bit cell mux selects.
// Rotate modes are only decoded when USR_ROTATE_EN is defined.
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_SHR  = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_LOAD = 3'b011;
    localparam mode_t MODE_ROR  = 3'b100;
    localparam mode_t MODE_ROL  = 3'b101;

    typedef logic [1:0] cell_sel_t;

    // LEFT takes bit i+1 (shift right), RIGHT takes bit i-1 (shift left)
    localparam cell_sel_t CELL_HOLD  = 2'd0;
    localparam cell_sel_t CELL_LEFT  = 2'd1;
    localparam cell_sel_t CELL_RIGHT = 2'd2;
    localparam cell_sel_t CELL_LOAD  = 2'd3;

endpackage

// File: rtl/usr_bit_cell.sv
// One register bit: 4:1 next-value mux feeding an async-reset flop with its own reset value.
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       left,
    input  logic       right,
    input  logic       load_bit,
    output logic       q
);

    logic d;

    always_comb begin
        d = q;
        case (sel)
            CELL_HOLD:  d = q;
            CELL_LEFT:  d = left;
            CELL_RIGHT: d = right;
            CELL_LOAD:  d = load_bit;
            default:    d = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with word counting.
// Define USR_ROTATE_EN to add the ROR/ROL modes; otherwise those encodings act as HOLD.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int unsigned      CNT_W     = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mode,
    input  logic              sin,
    input  logic [WIDTH-1:0]  pin,
    output logic [WIDTH-1:0]  pout,
    output logic              sout,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              word_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q;
    logic [1:0]       sel;
    logic             shift_r;
    logic             shift_l;
    logic             load;
    logic             shr_in;
    logic             shl_in;
    logic             dir;

    always_comb begin
        sel     = CELL_HOLD;
        shift_r = 1'b0;
        shift_l = 1'b0;
        load    = 1'b0;
        case (mode)
            MODE_SHR: begin
                sel     = CELL_LEFT;
                shift_r = 1'b1;
            end
            MODE_SHL: begin
                sel     = CELL_RIGHT;
                shift_l = 1'b1;
            end
            MODE_LOAD: begin
                sel  = CELL_LOAD;
                load = 1'b1;
            end
`ifdef USR_ROTATE_EN
            MODE_ROR: begin
                sel     = CELL_LEFT;
                shift_r = 1'b1;
            end
            MODE_ROL: begin
                sel     = CELL_RIGHT;
                shift_l = 1'b1;
            end
`endif
            default: sel = CELL_HOLD;
        endcase
    end

`ifdef USR_ROTATE_EN
    // Rotates reuse the shift paths; only the bit entering at the edge changes
    always_comb begin
        shr_in = sin;
        shl_in = sin;
        if (mode == MODE_ROR) shr_in = q[0];
        if (mode == MODE_ROL) shl_in = q[WIDTH-1];
    end
`else
    assign shr_in = sin;
    assign shl_in = sin;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic left_nb;
        logic right_nb;

        if (i == WIDTH - 1) begin : g_top
            assign left_nb = shr_in;
        end else begin : g_mid_l
            assign left_nb = q[i+1];
        end

        if (i == 0) begin : g_bot
            assign right_nb = shl_in;
        end else begin : g_mid_r
            assign right_nb = q[i-1];
        end

        usr_bit_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .sel      (sel),
            .left     (left_nb),
            .right    (right_nb),
            .load_bit (pin[i]),
            .q        (q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir        <= 1'b0;
            bit_cnt    <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (shift_r) dir <= 1'b0;
            if (shift_l) dir <= 1'b1;
            if (load) begin
                bit_cnt <= '0;
            end else if (shift_r || shift_l) begin
                if (bit_cnt == CNT_MAX) begin
                    bit_cnt    <= '0;
                    word_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign pout = q;
    assign sout = dir ? q[WIDTH-1] : q[0];

endmodule
